hexbus_master: RTL and testbench

HEXBUS_MASTER -- requirements
Module: hexbus_master

---
 rtl/hexbus_master.sv | 152 +++++++++++++++
 tb/tb_hexbus_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hexbus_master.sv
// hexbus_master: command-word driven bus master for a UART debug bridge.
// Accepts 34-bit command words (read / write / set address / special),
// runs a single bus transaction, and returns one 34-bit response word.
// Optional feature macro: HEXBUS_MASTER_TIMEOUT_EN aborts a bus cycle that
// sees no ack/err within TIMEOUT_CYCLES bus cycles.
module hexbus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stb,
  input  logic [33:0] i_word,
  output logic        o_busy,
  output logic        o_bus_cyc,
  output logic        o_bus_stb,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_data,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_data,
  output logic        o_rsp_stb,
  output logic [33:0] o_rsp_word,
  input  logic        i_rsp_busy,
  output logic        o_overrun
);

  // Elaboration-time range guard on the timeout length.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("hexbus_master: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RSP
  } state_t;

  state_t      state;
  logic [31:0] addr_q;

`ifdef HEXBUS_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic [16:0] tmo_next;
  logic        tmo_hit;

  // Count after this BUS cycle; expiry when it reaches the limit.
  always_comb begin
    tmo_next = {1'b0, tmo_cnt} + 17'd1;
    tmo_hit  = (tmo_next == 17'(TIMEOUT_CYCLES));
  end
`endif

  // Command sequencer: IDLE accepts a word, BUS runs the transaction,
  // RSP presents the response until the sink accepts it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      o_busy     <= 1'b0;
      o_bus_cyc  <= 1'b0;
      o_bus_stb  <= 1'b0;
      o_bus_we   <= 1'b0;
      o_bus_addr <= '0;
      o_bus_data <= '0;
      o_rsp_stb  <= 1'b0;
      o_rsp_word <= '0;
      o_overrun  <= 1'b0;
`ifdef HEXBUS_MASTER_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_stb) begin
            o_busy <= 1'b1;
            case (i_word[33:32])
              2'b10: begin
                addr_q     <= i_word[31:0];
                o_rsp_word <= {2'b10, i_word[31:0]};
                o_rsp_stb  <= 1'b1;
                state      <= S_RSP;
              end
              2'b11: begin
                o_rsp_word <= {2'b11, 32'h0000_0001};
                o_rsp_stb  <= 1'b1;
                state      <= S_RSP;
              end
              default: begin
                o_bus_cyc  <= 1'b1;
                o_bus_stb  <= 1'b1;
                o_bus_we   <= i_word[32];
                o_bus_addr <= addr_q;
                o_bus_data <= i_word[32] ? i_word[31:0] : '0;
`ifdef HEXBUS_MASTER_TIMEOUT_EN
                tmo_cnt    <= '0;
`endif
                state      <= S_BUS;
              end
            endcase
          end
        end

        S_BUS: begin
          if (i_stb)
            o_overrun <= 1'b1;
          // err beats ack; both beat the timeout in the same cycle
          if (i_bus_err) begin
            o_bus_cyc  <= 1'b0;
            o_bus_stb  <= 1'b0;
            o_rsp_word <= {2'b11, 32'h0000_0000};
            o_rsp_stb  <= 1'b1;
            state      <= S_RSP;
          end else if (i_bus_ack) begin
            o_bus_cyc  <= 1'b0;
            o_bus_stb  <= 1'b0;
            o_rsp_word <= o_bus_we ? {2'b01, o_bus_addr} : {2'b00, i_bus_data};
            o_rsp_stb  <= 1'b1;
            addr_q     <= addr_q + 32'd1;
            state      <= S_RSP;
          end
`ifdef HEXBUS_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            o_bus_cyc  <= 1'b0;
            o_bus_stb  <= 1'b0;
            o_rsp_word <= {2'b11, 32'h0000_0002};
            o_rsp_stb  <= 1'b1;
            state      <= S_RSP;
          end else begin
            tmo_cnt <= tmo_next[15:0];
          end
`endif
        end

        S_RSP: begin
          if (i_stb)
            o_overrun <= 1'b1;
          if (!i_rsp_busy) begin
            o_rsp_stb <= 1'b0;
            o_busy    <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hexbus_master.sv
// Directed self-checking bench for hexbus_master.
module tb_hexbus_master;

  logic        clk;
  logic        reset_n;
  logic        stb;
  logic [33:0] word;
  logic        busy;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;
  logic        rsp_stb;
  logic [33:0] rsp_word;
  logic        rsp_busy;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  hexbus_master #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_stb      (stb),
    .i_word     (word),
    .o_busy     (busy),
    .o_bus_cyc  (bus_cyc),
    .o_bus_stb  (bus_stb),
    .o_bus_we   (bus_we),
    .o_bus_addr (bus_addr),
    .o_bus_data (bus_wdata),
    .i_bus_ack  (bus_ack),
    .i_bus_err  (bus_err),
    .i_bus_data (bus_rdata),
    .o_rsp_stb  (rsp_stb),
    .o_rsp_word (rsp_word),
    .i_rsp_busy (rsp_busy),
    .o_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [33:0] w);
    stb  = 1'b1;
    word = w;
    step();
    stb  = 1'b0;
    word = '0;
  endtask

  task automatic ack_once(input logic [31:0] d);
    bus_ack   = 1'b1;
    bus_rdata = d;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
  endtask

  // Let the pending response complete (rsp_busy low), bounded.
  task automatic drain();
    int n = 0;
    rsp_busy = 1'b0;
    while (rsp_stb && n < 10) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_cmp++;
    if ({busy, bus_cyc, bus_stb, bus_we, rsp_stb, overrun} !== 6'b0 ||
        bus_addr !== 32'h0 || bus_wdata !== 32'h0 || rsp_word !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b cyc=%b stb=%b we=%b rsp_stb=%b ovr=%b addr=%h data=%h rsp=%h, required all zero",
               busy, bus_cyc, bus_stb, bus_we, rsp_stb, overrun, bus_addr, bus_wdata, rsp_word);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_setaddr_read();
    send({2'b10, 32'h10});
    n_cmp++;
    if (busy !== 1'b1 || rsp_stb !== 1'b1 || rsp_word !== {2'b10, 32'h10} || bus_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL setaddr_rsp: busy=%b rsp_stb=%b rsp=%h cyc=%b, required 1 1 %h 0",
               busy, rsp_stb, rsp_word, bus_cyc, {2'b10, 32'h10});
    end
    step();
    n_cmp++;
    if (rsp_stb !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL setaddr_done: rsp_stb=%b busy=%b, required 0 0", rsp_stb, busy);
    end
    send({2'b00, 32'h5555_5555});
    n_cmp++;
    if (bus_cyc !== 1'b1 || bus_stb !== 1'b1 || bus_we !== 1'b0 ||
        bus_addr !== 32'h10 || bus_wdata !== 32'h0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL read_bus: cyc=%b stb=%b we=%b addr=%h data=%h busy=%b, required 1 1 0 00000010 00000000 1",
               bus_cyc, bus_stb, bus_we, bus_addr, bus_wdata, busy);
    end
    step();
    step();
    n_cmp++;
    if (bus_cyc !== 1'b1 || bus_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL read_hold: cyc=%b addr=%h, required 1 00000010", bus_cyc, bus_addr);
    end
    ack_once(32'hDEAD_BEEF);
    n_cmp++;
    if (bus_cyc !== 1'b0 || bus_stb !== 1'b0 || rsp_stb !== 1'b1 || rsp_word !== {2'b00, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL read_rsp: cyc=%b stb=%b rsp_stb=%b rsp=%h, required 0 0 1 %h",
               bus_cyc, bus_stb, rsp_stb, rsp_word, {2'b00, 32'hDEAD_BEEF});
    end
    drain();
  endtask

  task automatic test_write_backpressure();
    int n = 0;
    send({2'b01, 32'hCAFE_0001});
    n_cmp++;
    if (bus_cyc !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h11 || bus_wdata !== 32'hCAFE_0001) begin
      n_bad++;
      $display("FAIL write_bus: cyc=%b we=%b addr=%h data=%h, required 1 1 00000011 cafe0001",
               bus_cyc, bus_we, bus_addr, bus_wdata);
    end
    rsp_busy = 1'b1;
    ack_once(32'h0);
    while (rsp_stb && n < 20) begin
      n++;
      if (n >= 5) rsp_busy = 1'b0;
      // stray ack while waiting on the response sink must be ignored
      bus_ack = (n == 2);
      if (rsp_word !== {2'b01, 32'h11}) begin
        n_cmp++;
        n_bad++;
        $display("FAIL write_rsp_word: rsp=%h at cycle %0d, required %h", rsp_word, n, {2'b01, 32'h11});
      end
      step();
      bus_ack = 1'b0;
    end
    rsp_busy = 1'b0;
    n_cmp++;
    if (n !== 5) begin
      n_bad++;
      $display("FAIL write_rsp_hold: rsp_stb high %0d cycles, required 5", n);
    end
    n_cmp++;
    if (busy !== 1'b0 || bus_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL write_idle: busy=%b cyc=%b, required 0 0", busy, bus_cyc);
    end
  endtask

  task automatic test_err_precedence();
    send({2'b00, 32'h0});
    n_cmp++;
    if (bus_addr !== 32'h12) begin
      n_bad++;
      $display("FAIL err_addr_before: addr=%h, required 00000012", bus_addr);
    end
    bus_err = 1'b1;
    ack_once(32'h1234_5678);
    bus_err = 1'b0;
    n_cmp++;
    if (rsp_stb !== 1'b1 || rsp_word !== {2'b11, 32'h0} || bus_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL err_rsp: rsp_stb=%b rsp=%h cyc=%b, required 1 %h 0", rsp_stb, rsp_word, bus_cyc, {2'b11, 32'h0});
    end
    drain();
    send({2'b00, 32'h0});
    n_cmp++;
    if (bus_addr !== 32'h12) begin
      n_bad++;
      $display("FAIL err_addr_after: addr=%h, required 00000012", bus_addr);
    end
    ack_once(32'h0);
    drain();
  endtask

  task automatic test_special();
    send({2'b11, 32'hABCD_0000});
    n_cmp++;
    if (rsp_stb !== 1'b1 || rsp_word !== {2'b11, 32'h1} || bus_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL special_rsp: rsp_stb=%b rsp=%h cyc=%b, required 1 %h 0", rsp_stb, rsp_word, bus_cyc, {2'b11, 32'h1});
    end
    drain();
  endtask

  task automatic test_wrap_overrun();
    send({2'b10, 32'hFFFF_FFFF});
    drain();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clear: ovr=%b, required 0", overrun);
    end
    send({2'b00, 32'h0});
    send({2'b10, 32'h0000_00AA});
    n_cmp++;
    if (overrun !== 1'b1 || bus_cyc !== 1'b1 || bus_addr !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL overrun_set: ovr=%b cyc=%b addr=%h, required 1 1 ffffffff", overrun, bus_cyc, bus_addr);
    end
    ack_once(32'h0BAD_F00D);
    n_cmp++;
    if (rsp_word !== {2'b00, 32'h0BAD_F00D}) begin
      n_bad++;
      $display("FAIL wrap_rsp: rsp=%h, required %h", rsp_word, {2'b00, 32'h0BAD_F00D});
    end
    drain();
    send({2'b00, 32'h0});
    n_cmp++;
    if (bus_addr !== 32'h0 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_addr: addr=%h ovr=%b, required 00000000 1", bus_addr, overrun);
    end
    ack_once(32'h0);
    drain();
  endtask

  task automatic test_timeout();
    int n = 0;
    send({2'b00, 32'h0});
`ifdef HEXBUS_MASTER_TIMEOUT_EN
    while (bus_cyc && n < 20) begin
      n++;
      step();
    end
    n_cmp++;
    if (n !== 4) begin
      n_bad++;
      $display("FAIL timeout_len: cyc high %0d cycles, required 4", n);
    end
    n_cmp++;
    if (rsp_stb !== 1'b1 || rsp_word !== {2'b11, 32'h2}) begin
      n_bad++;
      $display("FAIL timeout_rsp: rsp_stb=%b rsp=%h, required 1 %h", rsp_stb, rsp_word, {2'b11, 32'h2});
    end
    drain();
`else
    while (bus_cyc && n < 1000) begin
      n++;
      step();
    end
    n_cmp++;
    if (n !== 1000 || bus_cyc !== 1'b1 || rsp_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL no_timeout: cyc held %0d cycles cyc=%b rsp_stb=%b, required 1000 1 0", n, bus_cyc, rsp_stb);
    end
    ack_once(32'h0);
    drain();
`endif
  endtask

  task automatic test_reset_mid_bus();
    send({2'b00, 32'h0});
    n_cmp++;
    if (bus_cyc !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_bus_pre: cyc=%b, required 1", bus_cyc);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_cmp++;
    if (bus_cyc !== 1'b0 || rsp_stb !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_bus: cyc=%b rsp_stb=%b busy=%b ovr=%b, required 0 0 0 0", bus_cyc, rsp_stb, busy, overrun);
    end
    step();
    n_cmp++;
    if (rsp_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_rsp: rsp_stb=%b, required 0", rsp_stb);
    end
    // address register was cleared, so a read goes to 0
    send({2'b00, 32'h0});
    n_cmp++;
    if (bus_cyc !== 1'b1 || bus_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_idle_read: cyc=%b addr=%h, required 1 00000000", bus_cyc, bus_addr);
    end
    ack_once(32'h0);
    drain();
  endtask

  initial begin
    reset_n   = 1'b0;
    stb       = 1'b0;
    word      = '0;
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = '0;
    rsp_busy  = 1'b0;
    step();
    test_reset();
    test_setaddr_read();
    test_write_backpressure();
    test_err_precedence();
    test_special();
    test_wrap_overrun();
    test_timeout();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
